// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the bit-packed sample FIFO controller.
package fifo_ctrl_pkg;

    localparam int DEF_WR_W     = 16;
    localparam int DEF_RD_W     = 24;
    localparam int DEF_BUF_SIZE = 512;
    localparam int DEF_LW_MARK  = 128;
    localparam int DEF_SETTLE   = 2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        POP,
        SETTLE,
        FLUSH
    } state_t;

    // Fill level must be able to represent a completely full buffer.
    function automatic int level_width(input int buf_bits);
        return $clog2(buf_bits) + 1;
    endfunction

endpackage

// File: rtl/fifo_stream_ctrl_edge_det.sv
// Registered rising/falling edge detector used for the run start/stop edges.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d && !d_q;
    assign fall = !d && d_q;

endmodule

// File: rtl/fifo_stream_ctrl.sv
// Write/pop sequencer for the bit-packed sample FIFO feeding the audio path.
// Optional FIFO_CTRL_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module fifo_stream_ctrl
    import fifo_ctrl_pkg::state_t, fifo_ctrl_pkg::IDLE, fifo_ctrl_pkg::RUN,
           fifo_ctrl_pkg::POP, fifo_ctrl_pkg::FLUSH, fifo_ctrl_pkg::level_width,
           fifo_ctrl_pkg::DEF_WR_W, fifo_ctrl_pkg::DEF_RD_W, fifo_ctrl_pkg::DEF_BUF_SIZE,
           fifo_ctrl_pkg::DEF_LW_MARK, fifo_ctrl_pkg::DEF_SETTLE;
#(
    parameter int WR_W     = DEF_WR_W,
    parameter int RD_W     = DEF_RD_W,
    parameter int BUF_SIZE = DEF_BUF_SIZE,
    parameter int LW_MARK  = DEF_LW_MARK,
    parameter int SETTLE   = DEF_SETTLE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            wr_valid,
    input  logic [WR_W-1:0] wr_data,
    output logic            wr_ready,
    input  logic            sample_tick,
    output logic [WR_W-1:0] fifo_din,
    output logic            fifo_we,
    output logic            fifo_pop,
    output logic            fifo_clear,
    input  logic [RD_W-1:0] fifo_dout,
    input  logic            fifo_hw,
    output logic [RD_W-1:0] sample_out,
    output logic            sample_vld,
    output logic            refill_req,
`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
    output logic [15:0]     underrun_cnt,
`endif
    output logic            underrun
);

    localparam int LVL_W = level_width(BUF_SIZE);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [LVL_W:0]   WR_STEP     = (LVL_W+1)'(WR_W);
    localparam logic [LVL_W:0]   BUF_CAP     = (LVL_W+1)'(BUF_SIZE);
    localparam logic [LVL_W-1:0] RD_STEP     = LVL_W'(RD_W);
    localparam logic [LVL_W-1:0] LW_LEVEL    = LVL_W'(LW_MARK);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t            state_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [LVL_W:0]    level_after_wr;
    logic [CNT_W-1:0]  settle_cnt;
    logic              pending;
    logic              run_rise;
    logic              run_fall;
    logic              running;
    logic              flush_now;
    logic              start_now;
    logic              wr_acc;
    logic              pop_now;
    logic              tick_svc;
    logic              tick_wait;
    logic              underrun_evt;

    edge_det u_run_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (run),
        .rise  (run_rise),
        .fall  (run_fall)
    );

    // SETTLE is both a parameter and a state, so the state is package-qualified.
    assign running   = (state_q == RUN) || (state_q == POP) || (state_q == fifo_ctrl_pkg::SETTLE);
    assign flush_now = run_fall && running;
    assign start_now = run_rise && (state_q == IDLE);

    assign level_after_wr = {1'b0, level_q} + WR_STEP;
    assign wr_ready       = running && !fifo_hw && (level_after_wr <= BUF_CAP);
    assign wr_acc         = wr_valid && wr_ready;

    assign pop_now   = (state_q == POP) && !flush_now;
    assign tick_svc  = (state_q == RUN) && (pending || sample_tick) && !flush_now;
    assign tick_wait = ((state_q == POP) || (state_q == fifo_ctrl_pkg::SETTLE))
                       && sample_tick && !flush_now;

    // Either a serviced tick that finds too few bits, or a tick dropped while one is pending.
    assign underrun_evt = (tick_svc && (level_q < RD_STEP)) || (tick_wait && pending);

    always_comb begin
        // NOTE: assign a default before any condition so no path leaves level_d unassigned (no latch).
        level_d = level_q;
        if (wr_acc) begin
            level_d = level_d + WR_STEP[LVL_W-1:0];
        end
        if (pop_now) begin
            level_d = level_d - RD_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            level_q    <= '0;
            settle_cnt <= '0;
            pending    <= 1'b0;
            fifo_din   <= '0;
            fifo_we    <= 1'b0;
            fifo_pop   <= 1'b0;
            fifo_clear <= 1'b0;
            sample_out <= '0;
            sample_vld <= 1'b0;
            refill_req <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every decision below reads the pre-edge register values.
            fifo_we    <= wr_acc && !flush_now;
            fifo_pop   <= 1'b0;
            fifo_clear <= 1'b0;
            sample_vld <= 1'b0;
            level_q    <= level_d;
            refill_req <= running && (level_q < LW_LEVEL);
            if (wr_acc) begin
                fifo_din <= wr_data;
            end
            if (underrun_evt) begin
                underrun <= 1'b1;
            end

            if (flush_now) begin
                state_q    <= FLUSH;
                fifo_clear <= 1'b1;
                pending    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_now) begin
                            underrun <= 1'b0;
                            pending  <= 1'b0;
                            state_q  <= RUN;
                        end
                    end
                    RUN: begin
                        if (tick_svc) begin
                            // A fresh tick arriving while a pending one is serviced stays queued.
                            pending <= pending && sample_tick;
                            if (level_q >= RD_STEP) begin
                                state_q <= POP;
                            end else begin
                                sample_out <= '0;
                                sample_vld <= 1'b1;
                            end
                        end
                    end
                    POP: begin
                        sample_out <= fifo_dout;
                        sample_vld <= 1'b1;
                        fifo_pop   <= 1'b1;
                        settle_cnt <= SETTLE_LAST;
                        state_q    <= fifo_ctrl_pkg::SETTLE;
                    end
                    fifo_ctrl_pkg::SETTLE: begin
                        if (settle_cnt == '0) begin
                            state_q <= RUN;
                        end else begin
                            settle_cnt <= settle_cnt - CNT_W'(1);
                        end
                    end
                    FLUSH: begin
                        level_q <= '0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
                if (tick_wait && !pending) begin
                    pending <= 1'b1;
                end
            end
        end
    end

`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (start_now) begin
            underrun_cnt <= '0;
        end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Self-checking bench for fifo_stream_ctrl: vector table for the write handshake,
// scoreboard of expected samples, hand sequences for pending ticks, flush and reset.
module tb_fifo_stream_ctrl;
    import fifo_ctrl_pkg::*;

    localparam logic [23:0] BASE = 24'hA5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        sample_tick;
    logic [15:0] fifo_din;
    logic        fifo_we;
    logic        fifo_pop;
    logic        fifo_clear;
    logic [23:0] fifo_dout = BASE;
    logic        fifo_hw;
    logic [23:0] sample_out;
    logic        sample_vld;
    logic        refill_req;
    logic        underrun;
`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [23:0] sample;
        logic        is_pop;
    } exp_t;

    typedef struct {
        logic        wr_valid;
        logic [15:0] wr_data;
        logic        fifo_hw;
        logic        exp_ready;
        logic        exp_we;
        logic [9:0]  exp_level;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   pops_issued = 0;
    int   pops_seen   = 0;
    logic pop_prev    = 1'b0;

    fifo_stream_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .sample_tick  (sample_tick),
        .fifo_din     (fifo_din),
        .fifo_we      (fifo_we),
        .fifo_pop     (fifo_pop),
        .fifo_clear   (fifo_clear),
        .fifo_dout    (fifo_dout),
        .fifo_hw      (fifo_hw),
        .sample_out   (sample_out),
        .sample_vld   (sample_vld),
        .refill_req   (refill_req),
`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every sample_vld must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pop_prev = 1'b0;
            end else begin
                if (fifo_pop) begin
                    check("pop_single_cycle", 32'(pop_prev), 32'd0);
                end
                if (sample_vld) begin
                    check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("sample_out", 32'(sample_out), 32'(e.sample));
                        check("pop_with_sample", 32'(fifo_pop), 32'(e.is_pop));
                    end
                end
                if (fifo_pop) begin
                    pops_seen++;
                    fifo_dout = BASE + 24'(pops_seen);
                end
                pop_prev = fifo_pop;
            end
        end
    end

    task automatic push_exp(input bit pop);
        exp_t e;
        e.is_pop = pop;
        e.sample = pop ? BASE + 24'(pops_issued) : 24'd0;
        if (pop) pops_issued++;
        exp_q.push_back(e);
    endtask

    task automatic pulse_tick(input int n);
        sample_tick = 1'b1;
        repeat (n) @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic tick_expect(input bit pop);
        @(negedge clk);
        push_exp(pop);
        pulse_tick(1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pop();
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = fifo_pop;
        end
        check("pop_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic write_words(input int n);
        int sent = 0;
        int budget = 0;
        while (sent < n && budget < 4 * n + 8) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = 16'h4000 + 16'(sent);
            #1;
            if (wr_ready) sent++;
            budget++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check("write_words_accepted", 32'(sent), 32'(n));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_ready"},   32'(wr_ready),   32'd0);
        check({tag, "_fifo_we"},    32'(fifo_we),    32'd0);
        check({tag, "_fifo_pop"},   32'(fifo_pop),   32'd0);
        check({tag, "_fifo_clear"}, 32'(fifo_clear), 32'd0);
        check({tag, "_sample_vld"}, 32'(sample_vld), 32'd0);
        check({tag, "_refill_req"}, 32'(refill_req), 32'd0);
        check({tag, "_underrun"},   32'(underrun),   32'd0);
        check({tag, "_sample_out"}, 32'(sample_out), 32'd0);
        check({tag, "_fifo_din"},   32'(fifo_din),   32'd0);
`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
        check({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'd0);
`endif
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 10'd16};
        vecs[1] = '{1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 10'd16};
        vecs[2] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 10'd32};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 10'd32};
        vecs[4] = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 10'd48};

        rst_n = 1'b0; run = 1'b0; wr_valid = 1'b0; wr_data = '0;
        sample_tick = 1'b0; fifo_hw = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Start, then the write-handshake vector table.
        @(negedge clk) run = 1'b1;
        @(negedge clk);
        check("start_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wr_valid = vecs[i].wr_valid;
            wr_data  = vecs[i].wr_data;
            fifo_hw  = vecs[i].fifo_hw;
            #1;
            check("vec_wr_ready", 32'(wr_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check("vec_level", 32'(dut.level_q), 32'(vecs[i].exp_level));
            check("vec_fifo_we", 32'(fifo_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) check("vec_fifo_din", 32'(fifo_din), 32'(vecs[i].wr_data));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        fifo_hw  = 1'b0;

        // One pop from 48 bits.
        tick_expect(1'b1);
        idle(8);
        check("pop_level", 32'(dut.level_q), 32'd24);
        check("pop_refill_req", 32'(refill_req), 32'd1);
        check("pop_drained", 32'(exp_q.size()), 32'd0);

        // Drain, refill 16 bits, then underrun.
        tick_expect(1'b1);
        idle(8);
        check("drain_level", 32'(dut.level_q), 32'd0);
        write_words(1);
        check("level_16", 32'(dut.level_q), 32'd16);
        tick_expect(1'b0);
        idle(4);
        check("underrun_flag", 32'(underrun), 32'd1);
        check("underrun_sample", 32'(sample_out), 32'd0);
        check("underrun_level", 32'(dut.level_q), 32'd16);
`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
        check("underrun_cnt_1", 32'(underrun_cnt), 32'd1);
`endif

        // Tick during SETTLE is held and serviced afterwards.
        write_words(5);
        tick_expect(1'b1);
        wait_pop();
        push_exp(1'b1);
        pulse_tick(1);
        idle(10);
        check("pending_level", 32'(dut.level_q), 32'd48);
        check("pending_drained", 32'(exp_q.size()), 32'd0);

        // Stop with 200 bits buffered.
        write_words(11);
        tick_expect(1'b1);
        idle(8);
        check("stop_level_before", 32'(dut.level_q), 32'd200);
        begin
            int clr = 0;
            @(negedge clk) run = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (fifo_clear) clr++;
            end
            check("clear_pulse_cycles", 32'(clr), 32'd1);
        end
        check("stop_level", 32'(dut.level_q), 32'd0);
        check("stop_state", 32'(dut.state_q), 32'(IDLE));
        check("stop_refill_req", 32'(refill_req), 32'd0);
        check("stop_wr_ready", 32'(wr_ready), 32'd0);

        // Restart clears underrun; two ticks in SETTLE give one pop and an underrun.
        @(negedge clk) run = 1'b1;
        @(negedge clk);
        check("restart_underrun", 32'(underrun), 32'd0);
`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
        check("restart_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
        write_words(4);
        tick_expect(1'b1);
        wait_pop();
        push_exp(1'b1);
        pulse_tick(2);
        idle(10);
        check("double_tick_level", 32'(dut.level_q), 32'd16);
        check("double_tick_underrun", 32'(underrun), 32'd1);
        check("double_tick_drained", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_CTRL_UNDERRUN_CNT_EN
        check("double_tick_cnt", 32'(underrun_cnt), 32'd1);
`endif

        // Fill to capacity, then free one sample's worth.
        @(negedge clk) run = 1'b0;
        idle(3);
        run = 1'b1;
        idle(2);
        write_words(32);
        check("full_level", 32'(dut.level_q), 32'd512);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        tick_expect(1'b1);
        idle(8);
        check("after_full_level", 32'(dut.level_q), 32'd488);
        check("after_full_wr_ready", 32'(wr_ready), 32'd1);
        check("after_full_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a pop.
        tick_expect(1'b1);
        check("mid_pop_state", 32'(dut.state_q), 32'(POP));
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        check("async_reset_level", 32'(dut.level_q), 32'd0);
        exp_q.delete();
        pops_issued = pops_seen;
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        check("post_reset_state", 32'(dut.state_q), 32'(IDLE));
        check("post_reset_wr_ready", 32'(wr_ready), 32'd0);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
